// File: rtl/delay_timer_pkg.sv
// Shared types, defaults and the round-robin pick function for the delay timer arbiter.
package delay_timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int DIV_DEF  = 50_000_000;
    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 8;
    localparam int NREQ_MAX = 32;

    // First set bit searching last+1, last+2, ... modulo n; returns last when nothing is set.
    function automatic int rr_pick(input logic [NREQ_MAX-1:0] req, input int last, input int n);
        int         idx;
        logic [4:0] bit_idx;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int i = 1; i <= NREQ_MAX; i++) begin
            idx     = (last + i) % n;
            bit_idx = 5'(idx);
            if (!found && i <= n && req[bit_idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/delay_timer_arbiter_tick_prescaler.sv
// Divides clk by DIV; tick is high on the last count while enabled, clr restarts from 0.
module tick_prescaler #(
    parameter int DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/delay_timer_arbiter.sv
// Round-robin shared countdown timer: one owner at a time, done pulse on expiry.
// Define DELAY_TIMER_ABORT_EN to let the owner cancel its countdown by dropping req.
module delay_timer_arbiter
    import delay_timer_pkg::*;
#(
    parameter int DIV  = DIV_DEF,
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] delay,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic               tick,
    output logic [DW-1:0]      remaining
);

    localparam int IW = $clog2(NREQ);

    state_t              state;
    logic [IW-1:0]       last;
    logic [IW-1:0]       win_idx;
    logic [NREQ_MAX-1:0] req_w;
    logic [DW-1:0]       delay_arr [NREQ];
    logic [DW-1:0]       win_delay;
    int                  winner;

    always_comb begin
        req_w = '0;
        req_w[NREQ-1:0] = req;
        for (int i = 0; i < NREQ; i++) begin
            delay_arr[i] = delay[i*DW +: DW];
        end
        winner    = rr_pick(req_w, int'(last), NREQ);
        win_idx   = IW'(winner);
        win_delay = delay_arr[win_idx];
    end

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state != RUN),
        .en      (state == RUN),
        .tick    (tick)
    );

    assign busy = (state == RUN) || (state == DONE);

`ifdef DELAY_TIMER_ABORT_EN
    logic owner_req;
    assign owner_req = |(req & grant);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            grant     <= '0;
            done      <= '0;
            remaining <= '0;
            last      <= IW'(NREQ - 1);
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    grant     <= '0;
                    remaining <= '0;
                    if (|req) begin
                        grant     <= NREQ'(1) << win_idx;
                        remaining <= win_delay;
                        last      <= win_idx;
                        if (win_delay == '0) begin
                            state <= DONE;
                            done  <= NREQ'(1) << win_idx;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
`ifdef DELAY_TIMER_ABORT_EN
                    if (!owner_req) begin
                        // Silent cancel: pointer keeps the aborted owner so fairness is unchanged.
                        state     <= IDLE;
                        grant     <= '0;
                        remaining <= '0;
                    end else
`endif
                    if (tick && remaining != '0) begin
                        remaining <= remaining - DW'(1);
                        if (remaining == DW'(1)) begin
                            state <= DONE;
                            done  <= grant;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    grant     <= '0;
                    remaining <= '0;
                end
                default: begin
                    state     <= IDLE;
                    grant     <= '0;
                    remaining <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Directed bench for delay_timer_arbiter with DIV=10, NREQ=4, DW=8; cycle 0 is the cycle req is first seen.
module tb_delay_timer_arbiter;

    localparam int DIV  = 10;
    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] delay = '0;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic               tick;
    logic [DW-1:0]      remaining;

    int checks = 0;
    int errors = 0;

    delay_timer_arbiter #(.DIV(DIV), .NREQ(NREQ), .DW(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .delay     (delay),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .tick      (tick),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        repeat (3) step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req     = 4'b1111;
        delay   = {8'd1, 8'd1, 8'd1, 8'd1};
        repeat (3) step();
        checks++;
        if ({grant, done, busy, tick, remaining} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: grant=%b done=%b busy=%b tick=%b remaining=%0d, all required 0",
                     grant, done, busy, tick, remaining);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant: grant=%b required 0001", grant);
        end
    endtask

    task automatic test_single();
        logic [NREQ-1:0] e_grant, e_done;
        logic            e_tick;
        logic [DW-1:0]   e_rem;
        do_reset();
        delay = {8'd0, 8'd3, 8'd0, 8'd0};
        req   = 4'b0100;
        for (int cyc = 1; cyc <= 33; cyc++) begin
            step();
            e_grant = (cyc <= 31) ? 4'b0100 : 4'b0000;
            e_done  = (cyc == 31) ? 4'b0100 : 4'b0000;
            e_tick  = (cyc == 10 || cyc == 20 || cyc == 30);
            e_rem   = (cyc <= 10) ? 8'd3 : (cyc <= 20) ? 8'd2 : (cyc <= 30) ? 8'd1 : 8'd0;
            checks++;
            if ({grant, done, tick, remaining} !== {e_grant, e_done, e_tick, e_rem}) begin
                errors++;
                $display("FAIL single cycle %0d: grant=%b done=%b tick=%b rem=%0d, required %b %b %b %0d",
                         cyc, grant, done, tick, remaining, e_grant, e_done, e_tick, e_rem);
            end
            if (cyc == 31) req = '0;
        end
    endtask

    task automatic test_zero_delay();
        do_reset();
        delay = {8'd0, 8'd0, 8'd0, 8'd9};
        req   = 4'b0010;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            step();
            checks++;
            if ({done, busy, tick} !== {(cyc == 1) ? 4'b0010 : 4'b0000, cyc == 1, 1'b0}) begin
                errors++;
                $display("FAIL zero_delay cycle %0d: done=%b busy=%b tick=%b, required done=%b busy=%b tick=0",
                         cyc, done, busy, tick, (cyc == 1) ? 4'b0010 : 4'b0000, cyc == 1);
            end
            req = '0;
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] prev;
        logic [NREQ-1:0] exp_g [5];
        int              exp_c [5];
        int              n;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_c = '{1, 13, 25, 37, 49};
        do_reset();
        delay = {8'd1, 8'd1, 8'd1, 8'd1};
        req   = 4'b1111;
        prev  = '0;
        n     = 0;
        for (int cyc = 1; cyc <= 55; cyc++) begin
            step();
            if (grant !== '0 && prev === '0) begin
                checks++;
                if (n >= 5 || grant !== exp_g[n] || cyc != exp_c[n]) begin
                    errors++;
                    $display("FAIL rr_grant #%0d: grant=%b at cycle %0d, required %b at cycle %0d",
                             n, grant, cyc, (n < 5) ? exp_g[n] : 4'b0, (n < 5) ? exp_c[n] : -1);
                end
                n++;
            end
            prev = grant;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL rr_count: %0d grants seen, required 5", n);
        end
        req = '0;
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        delay = {8'd0, 8'd0, 8'd0, 8'd5};
        req   = 4'b0001;
        repeat (25) step();
        checks++;
        if (remaining !== 8'd3 || grant !== 4'b0001) begin
            errors++;
            $display("FAIL midrun_before: remaining=%0d grant=%b, required 3 0001", remaining, grant);
        end
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({grant, done, busy, tick, remaining} !== '0) begin
                errors++;
                $display("FAIL midrun_reset %0d: grant=%b done=%b busy=%b tick=%b remaining=%0d, required all 0",
                         k, grant, done, busy, tick, remaining);
            end
        end
        delay   = {8'd0, 8'd0, 8'd0, 8'd7};
        reset_n = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0001 || remaining !== 8'd7) begin
            errors++;
            $display("FAIL midrun_restart: grant=%b remaining=%0d, required 0001 7", grant, remaining);
        end
        req = '0;
    endtask

    task automatic test_abort();
        logic [NREQ-1:0] e_done, e_grant;
        do_reset();
        delay = {8'd4, 8'd0, 8'd0, 8'd0};
        req   = 4'b1000;
        for (int cyc = 1; cyc <= 44; cyc++) begin
            step();
`ifdef DELAY_TIMER_ABORT_EN
            e_done  = 4'b0000;
            e_grant = (cyc <= 15) ? 4'b1000 : 4'b0000;
`else
            e_done  = (cyc == 41) ? 4'b1000 : 4'b0000;
            e_grant = (cyc <= 41) ? 4'b1000 : 4'b0000;
`endif
            checks++;
            if (done !== e_done || grant !== e_grant) begin
                errors++;
                $display("FAIL abort cycle %0d: done=%b grant=%b, required %b %b",
                         cyc, done, grant, e_done, e_grant);
            end
            if (cyc == 15) req = '0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_delay();
        test_round_robin();
        test_reset_mid_run();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
